// File: rtl/libMdlu.sv
// Shared opcodes, FSM state and result-kind types for the multiply/divide unit.
package libMdlu;

    localparam logic [1:0] MDLU_MULT = 2'd0;
    localparam logic [1:0] MDLU_DIV  = 2'd1;
    localparam logic [1:0] MDLU_ZERO = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } mdlu_state_t;

    // What the FIX stage has to produce from the core registers.
    typedef enum logic [1:0] {
        KindMult,
        KindDiv,
        KindZero,
        KindDivZero
    } mdlu_kind_t;

    function automatic logic op_valid(input logic [1:0] code);
        return code != 2'd3;
    endfunction

endpackage

// File: rtl/mdlu_iter_core.sv
// Iterative datapath: unsigned shift-add multiply or restoring divide, one step per cycle.
module mdlu_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] hi_q, lo_q, m_q;
    logic             div_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Multiply: {hi,lo} holds partial product and multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - m_q;
        if (div_q) begin
            if (shifted >= {1'b0, m_q}) begin
                hi_d = diff;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= mag_a;
            m_q   <= mag_b;
            div_q <= div_mode;
        end else if (step) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

endmodule

// File: rtl/mdlu_controller.sv
// MIPS-style HI/LO multiply/divide controller: sequencing FSM, iteration counter,
// sign correction and the architectural HI/LO registers.
module mdlu_controller
    import libMdlu::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             readHiLo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

    mdlu_state_t      state_q;
    mdlu_kind_t       kind_q;
    mdlu_kind_t       op_kind;
    logic [CntW-1:0]  cnt_q;
    logic             neg_q;
    logic             neg_r;
    logic             accept;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign accept = start && (state_q == StIdle || state_q == StDone) && op_valid(op);
    assign mag_a  = operandA[WIDTH-1] ? -operandA : operandA;
    assign mag_b  = operandB[WIDTH-1] ? -operandB : operandB;
    assign stall  = busy & readHiLo;

    always_comb begin
        op_kind = KindZero;
        if (op == MDLU_MULT) begin
            op_kind = KindMult;
        end else if (op == MDLU_DIV) begin
            op_kind = (operandB == '0) ? KindDivZero : KindDiv;
        end
    end

    mdlu_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .load    (accept && op != MDLU_ZERO),
        .step    (state_q == StCalc),
        .div_mode(op == MDLU_DIV),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .acc_hi  (core_hi),
        .acc_lo  (core_lo)
    );

    // Divide-by-zero returns the original dividend; the core still holds its magnitude.
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_neg = -prod;
        fix_hi   = '0;
        fix_lo   = '0;
        unique case (kind_q)
            KindMult:    {fix_hi, fix_lo} = neg_q ? prod_neg : prod;
            KindDiv: begin
                fix_hi = neg_r ? -core_hi : core_hi;
                fix_lo = neg_q ? -core_lo : core_lo;
            end
            KindDivZero: begin
                fix_hi = neg_r ? -core_lo : core_lo;
                fix_lo = '1;
            end
            KindZero: begin
                fix_hi = '0;
                fix_lo = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            kind_q  <= KindZero;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        cnt_q   <= '0;
                        kind_q  <= op_kind;
                        neg_q   <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                        neg_r   <= operandA[WIDTH-1];
                        state_q <= (op_kind == KindMult || op_kind == KindDiv) ? StCalc : StFix;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi      <= fix_hi;
                    lo      <= fix_lo;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mdlu_controller.sv
// Self-checking bench for mdlu_controller: directed vectors, randomized ops, corner sequences.
module tb_mdlu_controller;
    import libMdlu::*;

    localparam int FULL_LAT = 34;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operandA, operandB;
    logic        readHiLo;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_hi, cur_lo;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    mdlu_controller #(
        .WIDTH(32),
        .ITER (32)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .operandA(operandA),
        .operandB(operandB),
        .readHiLo(readHiLo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: signed arithmetic on wide integers, with the two architectural special cases.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        int     q, r;
        if (o == MDLU_MULT) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        if (o == MDLU_DIV) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return 64'd0;
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
        if (o == 2'd3) return 0;
        if (o == MDLU_ZERO || (o == MDLU_DIV && b == 32'd0)) return 2;
        return FULL_LAT;
    endfunction

    task automatic expect_cycle(input string name, input int n, input logic b_e,
                                input logic d_e, input logic [31:0] h_e, input logic [31:0] l_e);
        logic [66:0] got, want;
        got  = {stall, busy, done, hi, lo};
        want = {b_e & readHiLo, b_e, d_e, h_e, l_e};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s k+%0d: got stall=%b busy=%b done=%b hi=%h lo=%h, want stall=%b busy=%b done=%b hi=%h lo=%h",
                     name, n, stall, busy, done, hi, lo, want[66], want[65], want[64],
                     want[63:32], want[31:0]);
        end
    endtask

    // Launch one op and follow it cycle by cycle; lat==0 means the start must be ignored.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int lat);
        op = o; operandA = a; operandB = b; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        operandA = $urandom;
        operandB = $urandom;
        if (lat == 0) begin
            for (int n = 1; n <= 2; n++) begin
                @(negedge clock);
                expect_cycle(name, n, 1'b0, 1'b0, cur_hi, cur_lo);
            end
        end else begin
            for (int n = 1; n <= lat + 1; n++) begin
                @(negedge clock);
                if (n < lat)       expect_cycle(name, n, 1'b1, 1'b0, cur_hi, cur_lo);
                else if (n == lat) expect_cycle(name, n, 1'b0, 1'b1, eh, el);
                else               expect_cycle(name, n, 1'b0, 1'b0, eh, el);
            end
            cur_hi = eh;
            cur_lo = el;
        end
    endtask

    initial begin
        logic [63:0] r1, r2;

        vecs[0]  = '{MDLU_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{MDLU_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        vecs[2]  = '{MDLU_DIV,  32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 2};
        vecs[3]  = '{MDLU_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
        vecs[4]  = '{MDLU_ZERO, 32'd9,          32'd9,         32'd0,         32'd0,         2};
        vecs[5]  = '{MDLU_MULT, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0,         34};
        vecs[6]  = '{MDLU_DIV,  32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
        vecs[7]  = '{MDLU_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         34};
        vecs[8]  = '{MDLU_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1,         34};
        vecs[9]  = '{MDLU_DIV,  32'h8000_0000,  32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 2};
        vecs[10] = '{MDLU_MULT, 32'hFFFF_FFFF,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 34};
        vecs[11] = '{2'd3,      32'd1,          32'd1,         32'd0,         32'd0,         0};
        vecs[12] = '{MDLU_DIV,  32'd100,        32'd7,         32'd2,         32'd14,        34};

        reset = 1'b1; start = 1'b0; op = 2'd0; operandA = '0; operandB = '0; readHiLo = 1'b0;
        cur_hi = '0; cur_lo = '0;
        #12;
        expect_cycle("reset_state", 0, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].lat);
        end

        for (int i = 0; i < 20; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            logic [63:0] r;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
            if ($urandom_range(0, 4) == 0) b = 32'd0;
            else if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
            r = model(o, a, b);
            run_op($sformatf("rand%0d", i), o, a, b, r[63:32], r[31:0], model_lat(o, b));
        end

        // MFHI/MFLO stall during a multiply, with a stray start mid-operation.
        r1 = model(MDLU_MULT, 32'd7, 32'hFFFF_FFFD);
        op = MDLU_MULT; operandA = 32'd7; operandB = 32'hFFFF_FFFD; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0; readHiLo = 1'b1;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clock);
            if (n < 34)       expect_cycle("stall", n, 1'b1, 1'b0, cur_hi, cur_lo);
            else if (n == 34) expect_cycle("stall", n, 1'b0, 1'b1, r1[63:32], r1[31:0]);
            else              expect_cycle("stall", n, 1'b0, 1'b0, r1[63:32], r1[31:0]);
            if (n == 10) begin
                op = MDLU_MULT; operandA = 32'd100; operandB = 32'd100; start = 1'b1;
            end
            if (n == 11) start = 1'b0;
        end
        readHiLo = 1'b0;
        cur_hi = r1[63:32];
        cur_lo = r1[31:0];

        // Reset in the middle of a multiply.
        op = MDLU_MULT; operandA = 32'h0001_0000; operandB = 32'h0001_0000; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clock);
            expect_cycle("pre_reset", n, 1'b1, 1'b0, cur_hi, cur_lo);
        end
        reset = 1'b1;
        #1;
        expect_cycle("mid_reset", 15, 1'b0, 1'b0, 32'd0, 32'd0);
        cur_hi = '0;
        cur_lo = '0;
        #1 reset = 1'b0;
        run_op("after_reset", MDLU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, FULL_LAT);

        // Start held high through DONE: second op chains with no gap.
        r1 = model(MDLU_MULT, 32'd7, 32'hFFFF_FFFD);
        r2 = model(MDLU_DIV, 32'hFFFF_FFF9, 32'd2);
        op = MDLU_MULT; operandA = 32'd7; operandB = 32'hFFFF_FFFD; start = 1'b1;
        @(posedge clock);
        #1 op = MDLU_DIV; operandA = 32'hFFFF_FFF9; operandB = 32'd2;
        for (int n = 1; n <= 69; n++) begin
            @(negedge clock);
            if (n < 34)       expect_cycle("b2b", n, 1'b1, 1'b0, cur_hi, cur_lo);
            else if (n == 34) expect_cycle("b2b", n, 1'b0, 1'b1, r1[63:32], r1[31:0]);
            else if (n < 68)  expect_cycle("b2b", n, 1'b1, 1'b0, r1[63:32], r1[31:0]);
            else if (n == 68) expect_cycle("b2b", n, 1'b0, 1'b1, r2[63:32], r2[31:0]);
            else              expect_cycle("b2b", n, 1'b0, 1'b0, r2[63:32], r2[31:0]);
            if (n == 35) start = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
